// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: command, operand and HI/LO result bundle of mult_div_unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
) ();
    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] A_Data;
    logic [WIDTH-1:0] B_Data;
    logic             Hi_Write;
    logic             Lo_Write;
    logic [WIDTH-1:0] C_Data;
    logic             Busy;
    logic             Done;
    logic             Div_Zero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, A_Data, B_Data, Hi_Write, Lo_Write, C_Data,
        input  Busy, Done, Div_Zero, Hi, Lo
    );

    modport slave (
        input  Start, Op, A_Data, B_Data, Hi_Write, Lo_Write, C_Data,
        output Busy, Done, Div_Zero, Hi, Lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: sequential MULT/MULTU/DIV/DIVU unit holding its result in HI/LO.
// Optional divider: define MDU_DIV_EN to build the restoring divider; without it
// DIV/DIVU complete one cycle after Start and leave Hi/Lo untouched.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic           Clk,
    input  logic           Reset_n,
    mult_div_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH:0]     sum;
    logic               neg_lo;
    logic               skip_q;
    logic               dz_q;
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic               start_skip;
    logic               start_dz;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
`ifdef MDU_DIV_EN
    logic               div_q;
    logic               neg_hi;
    logic [WIDTH:0]     trial;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
`endif

    // Operand conditioning at Start: magnitudes for signed ops and the early-exit decision.
    always_comb begin
        sgn        = ~bus.Op[0];
        a_neg      = sgn & bus.A_Data[WIDTH-1];
        b_neg      = sgn & bus.B_Data[WIDTH-1];
        a_mag      = a_neg ? -bus.A_Data : bus.A_Data;
        b_mag      = b_neg ? -bus.B_Data : bus.B_Data;
`ifdef MDU_DIV_EN
        start_dz   = bus.Op[1] & (bus.B_Data == '0);
        start_skip = start_dz;
`else
        start_dz   = 1'b0;
        start_skip = bus.Op[1];
`endif
    end

    // One radix-2 step of the accumulator plus the sign-corrected final results.
    always_comb begin
        sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
`ifdef MDU_DIV_EN
        trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
        step  = div_q ? (trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                      : {sum, acc[WIDTH-1:1]};
        quo   = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem   = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`else
        step  = {sum, acc[WIDTH-1:1]};
`endif
        prod  = neg_lo ? -acc : acc;
    end

    // Control FSM: accept in IDLE, iterate WIDTH steps in CALC, commit and pulse Done in FIX.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            cnt          <= '0;
            acc          <= '0;
            opb          <= '0;
            neg_lo       <= 1'b0;
            skip_q       <= 1'b0;
            dz_q         <= 1'b0;
`ifdef MDU_DIV_EN
            div_q        <= 1'b0;
            neg_hi       <= 1'b0;
`endif
            bus.Busy     <= 1'b0;
            bus.Done     <= 1'b0;
            bus.Div_Zero <= 1'b0;
            bus.Hi       <= '0;
            bus.Lo       <= '0;
        end else begin
            bus.Done     <= 1'b0;
            bus.Div_Zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Hi_Write) bus.Hi <= bus.C_Data;
                    if (bus.Lo_Write) bus.Lo <= bus.C_Data;
                    if (bus.Start) begin
                        bus.Busy <= 1'b1;
                        cnt      <= '0;
                        acc      <= {{WIDTH{1'b0}}, a_mag};
                        opb      <= b_mag;
                        neg_lo   <= a_neg ^ b_neg;
                        skip_q   <= start_skip;
                        dz_q     <= start_dz;
`ifdef MDU_DIV_EN
                        div_q    <= bus.Op[1];
                        neg_hi   <= a_neg;
`endif
                        state    <= start_skip ? FIX : CALC;
                    end
                end
                CALC: begin
                    acc <= step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= FIX;
                end
                FIX: begin
                    bus.Busy     <= 1'b0;
                    bus.Done     <= 1'b1;
                    bus.Div_Zero <= dz_q;
`ifdef MDU_DIV_EN
                    if (!skip_q) {bus.Hi, bus.Lo} <= div_q ? {rem, quo} : prod;
`else
                    if (!skip_q) {bus.Hi, bus.Lo} <= prod;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: randomized self-checking bench for mult_div_unit against an arithmetic model.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mult_div_unit_if bus ();

    mult_div_unit dut (
        .Clk(clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic predict(input logic [1:0] op, input logic [31:0] a, b, output int lat, output logic dz);
        longint q;
        longint r;
        logic [63:0] p;
        lat = 33;
        dz = 1'b0;
        case (op)
            2'b00: begin
                q = longint'($signed(a)) * longint'($signed(b));
                {m_hi, m_lo} = q;
            end
            2'b01: begin
                p = {32'b0, a} * {32'b0, b};
                {m_hi, m_lo} = p;
            end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 0) begin
                    lat = 1;
                    dz = 1'b1;
                end else if (op == 2'b10) begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
`else
                lat = 1;
`endif
            end
        endcase
    endtask

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, b, input bit noise, input bit mt,
                          input logic [31:0] c, output int lat, output logic b0, output logic bd,
                          output logic dz, output logic [31:0] hi, output logic [31:0] lo);
        int n;
        bus.Start = 1'b1;
        bus.Op = op;
        bus.A_Data = a;
        bus.B_Data = b;
        bus.Hi_Write = mt;
        bus.Lo_Write = mt;
        bus.C_Data = c;
        @(posedge clk);
        @(negedge clk);
        b0 = bus.Busy;
        n = 0;
        while (!bus.Done && n < 100) begin
            bus.A_Data = $urandom;
            bus.B_Data = $urandom;
            bus.Op = 2'($urandom);
            bus.Start = noise && n == 5;
            bus.Hi_Write = noise && n == 7;
            bus.Lo_Write = noise && n == 7;
            bus.C_Data = $urandom;
            @(negedge clk);
            n++;
        end
        bus.Start = 1'b0;
        bus.Hi_Write = 1'b0;
        bus.Lo_Write = 1'b0;
        lat = n;
        bd = bus.Busy;
        dz = bus.Div_Zero;
        hi = bus.Hi;
        lo = bus.Lo;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
        checks++; if (bus.Done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus.Done); end
        checks++; if (bus.Div_Zero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", bus.Div_Zero); end
        checks++; if ({bus.Hi, bus.Lo} !== 64'd0) begin errors++; $display("FAIL reset_hilo got %h%h want 0", bus.Hi, bus.Lo); end
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
    endtask

    task automatic test_mult();
        logic [1:0] op;
        logic [31:0] a, b, hi, lo;
        logic b0, bd, dz, edz;
        int lat, elat;
        for (int i = 0; i < 14; i++) begin
            op = 2'($urandom_range(0, 1));
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            if (i == 0) begin op = 2'b00; a = 32'd7; b = 32'hFFFFFFFD; end
            if (i == 1) begin op = 2'b01; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; end
            if (i == 2) begin op = 2'b00; a = 32'd5; b = 32'd5; end
            if (i == 3) begin op = 2'b00; a = 32'h80000000; b = 32'h80000000; end
            predict(op, a, b, elat, edz);
            run_op(op, a, b, i % 2 == 1, 1'b0, 32'd0, lat, b0, bd, dz, hi, lo);
            checks++; if (lat !== elat) begin errors++; $display("FAIL mult%0d latency got %0d want %0d", i, lat, elat); end
            checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL mult%0d hilo got %h_%h want %h_%h", i, hi, lo, m_hi, m_lo); end
            checks++; if (b0 !== 1'b1 || bd !== 1'b0 || dz !== edz) begin errors++; $display("FAIL mult%0d flags got busy %b/%b dz %b want 1/0 %b", i, b0, bd, dz, edz); end
            @(negedge clk);
            checks++; if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) begin errors++; $display("FAIL mult%0d after done got done %b busy %b want 0 0", i, bus.Done, bus.Busy); end
        end
    endtask

    task automatic test_div();
        logic [1:0] op;
        logic [31:0] a, b, hi, lo;
        logic b0, bd, dz, edz;
        int lat, elat;
        for (int i = 0; i < 16; i++) begin
            op = {1'b1, 1'($urandom)};
            a = (i % 4 == 0) ? 32'h80000000 : $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : ((i % 5 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31));
            if (i == 0) begin op = 2'b10; a = 32'hFFFFFFF9; b = 32'd2; end
            if (i == 1) begin op = 2'b11; a = 32'd100; b = 32'd7; end
            if (i == 2) begin op = 2'b10; a = 32'h80000000; b = 32'hFFFFFFFF; end
            if (i == 3) begin op = 2'b10; a = 32'd10; b = 32'd2; end
            if (i == 4) begin op = 2'b10; a = 32'd7; b = 32'hFFFFFFFE; end
            predict(op, a, b, elat, edz);
            run_op(op, a, b, i % 2 == 1, 1'b0, 32'd0, lat, b0, bd, dz, hi, lo);
            checks++; if (lat !== elat) begin errors++; $display("FAIL div%0d latency got %0d want %0d", i, lat, elat); end
            checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL div%0d hilo got %h_%h want %h_%h", i, hi, lo, m_hi, m_lo); end
            checks++; if (b0 !== 1'b1 || bd !== 1'b0 || dz !== edz) begin errors++; $display("FAIL div%0d flags got busy %b/%b dz %b want 1/0 %b", i, b0, bd, dz, edz); end
            @(negedge clk);
            checks++; if (bus.Done !== 1'b0 || bus.Div_Zero !== 1'b0) begin errors++; $display("FAIL div%0d pulse width got done %b dz %b want 0 0", i, bus.Done, bus.Div_Zero); end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] c, hi, lo;
        logic [1:0] op;
        logic b0, bd, dz, edz;
        int lat, elat;
        c = $urandom;
        bus.Hi_Write = 1'b1;
        bus.Lo_Write = 1'b1;
        bus.C_Data = c;
        @(negedge clk);
        bus.Lo_Write = 1'b0;
        bus.C_Data = 32'h1234;
        checks++; if ({bus.Hi, bus.Lo} !== {c, c}) begin errors++; $display("FAIL mt_both got %h_%h want %h_%h", bus.Hi, bus.Lo, c, c); end
        @(negedge clk);
        bus.Hi_Write = 1'b0;
        bus.Lo_Write = 1'b1;
        bus.C_Data = 32'h5678;
        checks++; if ({bus.Hi, bus.Lo} !== {32'h1234, c}) begin errors++; $display("FAIL mthi got %h_%h want %h_%h", bus.Hi, bus.Lo, 32'h1234, c); end
        @(negedge clk);
        bus.Lo_Write = 1'b0;
        checks++; if ({bus.Hi, bus.Lo} !== 64'h00001234_00005678) begin errors++; $display("FAIL mtlo got %h_%h want 00001234_00005678", bus.Hi, bus.Lo); end
        m_hi = 32'h1234;
        m_lo = 32'h5678;
        for (int i = 0; i < 4; i++) begin
            op = (i == 1) ? 2'($urandom_range(0, 1)) : 2'b11;
            c = $urandom;
            if (i >= 1) begin m_hi = c; m_lo = c; end
            if (i == 3) op = 2'b10;
            predict(op, (i == 0) ? 32'd100 : 32'hDEAD, (i == 1) ? 32'd77 : 32'd0, elat, edz);
            run_op(op, (i == 0) ? 32'd100 : 32'hDEAD, (i == 1) ? 32'd77 : 32'd0, 1'b0, i >= 1, c, lat, b0, bd, dz, hi, lo);
            checks++; if (lat !== elat) begin errors++; $display("FAIL mt%0d latency got %0d want %0d", i, lat, elat); end
            checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL mt%0d hilo got %h_%h want %h_%h", i, hi, lo, m_hi, m_lo); end
            checks++; if (b0 !== 1'b1 || bd !== 1'b0 || dz !== edz) begin errors++; $display("FAIL mt%0d flags got busy %b/%b dz %b want 1/0 %b", i, b0, bd, dz, edz); end
        end
        repeat (3) @(negedge clk);
        checks++; if ({bus.Hi, bus.Lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL hold got %h_%h want %h_%h", bus.Hi, bus.Lo, m_hi, m_lo); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] hi, lo;
        logic b0, bd, dz, edz;
        int lat, elat;
        bus.Hi_Write = 1'b1;
        bus.Lo_Write = 1'b1;
        bus.C_Data = 32'hA5A5A5A5;
        bus.Start = 1'b1;
        bus.Op = 2'b00;
        bus.A_Data = $urandom;
        bus.B_Data = $urandom;
        @(negedge clk);
        bus.Start = 1'b0;
        bus.Hi_Write = 1'b0;
        bus.Lo_Write = 1'b0;
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin errors++; $display("FAIL midreset_ctl got busy %b done %b want 0 0", bus.Busy, bus.Done); end
        checks++; if ({bus.Hi, bus.Lo} !== 64'd0) begin errors++; $display("FAIL midreset_hilo got %h_%h want 0", bus.Hi, bus.Lo); end
        @(negedge clk);
        rst_n = 1'b1;
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        predict(2'b00, 32'd3, 32'd4, elat, edz);
        run_op(2'b00, 32'd3, 32'd4, 1'b0, 1'b0, 32'd0, lat, b0, bd, dz, hi, lo);
        checks++; if (lat !== elat) begin errors++; $display("FAIL postreset latency got %0d want %0d", lat, elat); end
        checks++; if ({hi, lo} !== 64'd12) begin errors++; $display("FAIL postreset hilo got %h_%h want 00000000_0000000c", hi, lo); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] op;
        logic [31:0] a, b, hi, lo;
        logic b0, bd, dz, edz;
        int lat, elat;
        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom);
            a = $urandom;
            b = (i == 2) ? 32'd0 : $urandom_range(0, 1000);
            predict(op, a, b, elat, edz);
            run_op(op, a, b, 1'b0, 1'b0, 32'd0, lat, b0, bd, dz, hi, lo);
            checks++; if (lat !== elat) begin errors++; $display("FAIL b2b%0d latency got %0d want %0d", i, lat, elat); end
            checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL b2b%0d hilo got %h_%h want %h_%h", i, hi, lo, m_hi, m_lo); end
            checks++; if (b0 !== 1'b1 || dz !== edz) begin errors++; $display("FAIL b2b%0d flags got busy %b dz %b want 1 %b", i, b0, dz, edz); end
        end
    endtask

    initial begin
        bus.Start = 1'b0;
        bus.Op = 2'b00;
        bus.A_Data = '0;
        bus.B_Data = '0;
        bus.Hi_Write = 1'b0;
        bus.Lo_Write = 1'b0;
        bus.C_Data = '0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
